dm9000a_bus_sequencer: RTL and testbench
========================================

# dm9000a_bus_sequencer

Two-port arbiter and bus-cycle sequencer in front of the DM9000A host interface. Turns single-word register read/write requests (register index plus data) from two requesters into timed index-phase and data-phase strobe cycles (CMD/CS_N/RD_N/WR_N). Sits between the CPU-side register agent (port 0) and the packet DMA engine (port 1), and drives the host-side inputs of the Ethernet interface.

## Interface
Parameters:
- SETUP_CYC, 1: cycles with CS_N low and strobes high before each strobe; range 1..15.
- STROBE_CYC, 2: cycles with RD_N/WR_N low; range 1..15.
- HOLD_CYC, 1: cycles after strobe release with CS_N low and data held; range 1..15.

Ports:
- iCLK  in  1  single clock; every output is a register on it.
- iRST  in  1  asynchronous reset, active-high.
- iREQ0 / iREQ1  in  1  level request; held until the matching ack.
- iWE0 / iWE1  in  1  1 = write, 0 = read.
- iADDR0 / iADDR1  in  8  DM9000A register index.
- iWDATA0 / iWDATA1  in  16  write data.
- oACK0 / oACK1  out  1  one-cycle completion pulse.
- oRDATA  out  16  read data; valid while oACK0 or oACK1 is high, held until the next read completes.
- oBUSY  out  1  high in every state except IDLE.
- oCMD  out  1  0 = index phase, 1 = data phase.
- oCS_N, oRD_N, oWR_N  out  1  bus strobes.
- oDATA  out  16  bus write data.
- iDATA  in  16  bus read data.

## Operation
- Reset values: oCS_N=1, oRD_N=1, oWR_N=1, oCMD=0, oDATA=0, oACK0=0, oACK1=0, oRDATA=0, oBUSY=0, index cache invalid, last-grant = port 1 (so port 0 wins first).
- States: IDLE, IDX_SETUP, IDX_STROBE, IDX_HOLD, DAT_SETUP, DAT_STROBE, DAT_HOLD, DONE.
- IDLE, arbitration:
  - One request pending: grant that port.
  - Both pending: grant the port not granted last (round-robin).
  - On grant, capture WE, ADDR and WDATA into internal registers. Later input changes are ignored.
- Index cache:
  - On grant, if the cache is valid and the captured ADDR equals the cached index, go to DAT_SETUP and skip the index phase.
  - Otherwise go to IDX_SETUP.
  - The cache is loaded with ADDR and marked valid at the end of IDX_HOLD.
- Index phase:
  - oCMD=0, oCS_N=0, oDATA={8'h00, ADDR}.
  - oWR_N=0 in IDX_STROBE only.
  - It is always a write.
- Data phase:
  - oCMD=1, oCS_N=0.
  - Write: oDATA=WDATA, oWR_N=0 in DAT_STROBE.
  - Read: oRD_N=0 in DAT_STROBE. iDATA is captured into oRDATA on the last DAT_STROBE cycle.
- Each phase state lasts exactly its parameter count. A 4-bit down-counter is reloaded on every state entry.
- DONE:
  - oCS_N=1 and all strobes high.
  - The granted port's oACK is 1 for this one cycle.
  - Next state is IDLE.
- The bus is idle (CS_N high) for at least 2 cycles (DONE and IDLE) between transactions.
- Strobes never overlap: oRD_N and oWR_N are never both 0, and neither is 0 while oCS_N=1.

## Timing
- First state after grant is entered on the edge that samples the request in IDLE.
- Index phase taken: oACK is high in cycle k+1+2·(SETUP_CYC+STROBE_CYC+HOLD_CYC), where k is the sampling edge. With defaults, oACK is high 9 cycles after the sampling edge.
- Index cache hit: latency is k+1+SETUP_CYC+STROBE_CYC+HOLD_CYC (5 with defaults).
- A requester drops iREQ on the edge ending its ack cycle. IDLE then samples the next request one edge later, which gives 1-cycle arbitration.
- Simultaneous iREQ0 and iREQ1 in IDLE: resolved in the same cycle by the round-robin rule. No cycle is lost.
- A request rising during a transaction waits in its line and is considered at the next IDLE.
- iRST asserted mid-transaction:
  - All outputs return to their reset values immediately, without waiting for a clock edge.
  - No ack is issued and the cache is invalidated.
  - The requester must re-issue the request.
- Counter wrap: not possible, because parameters are limited to 1..15 and the counter is reloaded on every state entry.

## Test plan
- Reset, then port 0 write ADDR=8'hFE, WDATA=16'h003F:
  - CMD=0, WR_N low for 2 cycles with oDATA=16'h00FE.
  - Then CMD=1, WR_N low for 2 cycles with oDATA=16'h003F.
  - oACK0 high 9 cycles after the request is sampled; oACK1 stays 0.
- Port 1 read ADDR=8'hF2 with the bus model returning 16'hA5C3:
  - oRDATA=16'hA5C3 during the oACK1 cycle.
  - RD_N is low only in the data phase.
- Back-to-back port 1 reads of ADDR=8'hF2:
  - The second read has no index phase (CMD stays 1 while CS_N is low).
  - oACK1 comes 5 cycles after sampling.
  - An intervening read of 8'h01 restores the index phase.
- iREQ0 and iREQ1 rise on the same edge after reset:
  - Port 0 is served first, then port 1.
  - With both requests held continuously, grants alternate 0,1,0,1.
- Reset pulse asserted during DAT_STROBE of a write:
  - oWR_N and oCS_N go to 1 before the next clock edge.
  - No ack is issued.
  - After release, a repeat of the same ADDR performs an index phase.
- Parameters SETUP=3, STROBE=5, HOLD=2:
  - Measured strobe widths are 5 cycles and CS_N low per phase is 10 cycles.
  - Full-transaction ack latency is 21 cycles.

Source files
------------

// File: rtl/dm9000a_bus_sequencer.sv
// Two-port round-robin arbiter and DM9000A host bus-cycle sequencer.
// Each request becomes an optional index write followed by a data read or write.
module dm9000a_bus_sequencer #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iREQ0,
    input  logic        iREQ1,
    input  logic        iWE0,
    input  logic        iWE1,
    input  logic [7:0]  iADDR0,
    input  logic [7:0]  iADDR1,
    input  logic [15:0] iWDATA0,
    input  logic [15:0] iWDATA1,
    output logic        oACK0,
    output logic        oACK1,
    output logic [15:0] oRDATA,
    output logic        oBUSY,
    output logic        oCMD,
    output logic        oCS_N,
    output logic        oRD_N,
    output logic        oWR_N,
    output logic [15:0] oDATA,
    input  logic [15:0] iDATA
);

    typedef enum logic [2:0] {
        IDLE, IDX_SETUP, IDX_STROBE, IDX_HOLD,
        DAT_SETUP, DAT_STROBE, DAT_HOLD, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;
    logic        cvld_q, cvld_d;
    logic [7:0]  cidx_q, cidx_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] data_q, data_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
    logic        cmd_q, cmd_d, cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic        last, idx_ph, dat_ph;

    function automatic logic [3:0] load_cnt(input state_t s);
        case (s)
            IDX_SETUP, DAT_SETUP:   load_cnt = 4'(SETUP_CYC);
            IDX_STROBE, DAT_STROBE: load_cnt = 4'(STROBE_CYC);
            IDX_HOLD, DAT_HOLD:     load_cnt = 4'(HOLD_CYC);
            default:                load_cnt = 4'd1;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        cvld_d  = cvld_q;
        cidx_d  = cidx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        last    = (cnt_q == 4'd1);
        case (state_q)
            IDLE: begin
                if (iREQ0 || iREQ1) begin
                    gnt_d   = (iREQ0 && iREQ1) ? ~gnt_q : iREQ1;
                    we_d    = gnt_d ? iWE1    : iWE0;
                    addr_d  = gnt_d ? iADDR1  : iADDR0;
                    wdata_d = gnt_d ? iWDATA1 : iWDATA0;
                    // Index register still selected from the last cycle: go straight to data
                    state_d = (cvld_q && cidx_q == addr_d) ? DAT_SETUP : IDX_SETUP;
                end
            end
            IDX_SETUP:  if (last) state_d = IDX_STROBE; else cnt_d = cnt_q - 4'd1;
            IDX_STROBE: if (last) state_d = IDX_HOLD;   else cnt_d = cnt_q - 4'd1;
            IDX_HOLD: begin
                if (last) begin
                    state_d = DAT_SETUP;
                    cvld_d  = 1'b1;
                    cidx_d  = addr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DAT_SETUP:  if (last) state_d = DAT_STROBE; else cnt_d = cnt_q - 4'd1;
            DAT_STROBE: begin
                if (last) begin
                    state_d = DAT_HOLD;
                    if (!we_q) rdata_d = iDATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DAT_HOLD:   if (last) state_d = DONE; else cnt_d = cnt_q - 4'd1;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = load_cnt(state_d);

        // Bus outputs are registered from the next state so they line up with it
        idx_ph = (state_d == IDX_SETUP) || (state_d == IDX_STROBE) || (state_d == IDX_HOLD);
        dat_ph = (state_d == DAT_SETUP) || (state_d == DAT_STROBE) || (state_d == DAT_HOLD);
        cs_n_d = !(idx_ph || dat_ph);
        cmd_d  = dat_ph;
        wr_n_d = !((state_d == IDX_STROBE) || (state_d == DAT_STROBE && we_d));
        rd_n_d = !(state_d == DAT_STROBE && !we_d);
        data_d = data_q;
        if (idx_ph)
            data_d = {8'h00, addr_d};
        else if (dat_ph && we_d)
            data_d = wdata_d;
        ack0_d = (state_d == DONE) && !gnt_d;
        ack1_d = (state_d == DONE) && gnt_d;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd1;
            gnt_q   <= 1'b1;
            cvld_q  <= 1'b0;
            cidx_q  <= 8'h00;
            rdata_q <= 16'h0000;
            data_q  <= 16'h0000;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            cmd_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            cvld_q  <= cvld_d;
            cidx_q  <= cidx_d;
            rdata_q <= rdata_d;
            data_q  <= data_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            cmd_q   <= cmd_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
        end
    end

    always_ff @(posedge iCLK) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign oACK0  = ack0_q;
    assign oACK1  = ack1_q;
    assign oRDATA = rdata_q;
    assign oBUSY  = busy_q;
    assign oCMD   = cmd_q;
    assign oCS_N  = cs_n_q;
    assign oRD_N  = rd_n_q;
    assign oWR_N  = wr_n_q;
    assign oDATA  = data_q;

endmodule

// File: tb/tb_dm9000a_bus_sequencer.sv
// Scoreboard bench for dm9000a_bus_sequencer with a small DM9000A register-file bus model.
// A second instance with stretched timing parameters checks strobe widths and latency.
module tb_dm9000a_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [7:0]  addr0 = 0, addr1 = 0;
    logic [15:0] wdata0 = 0, wdata1 = 0;
    logic        ack0, ack1, busy, cmd, cs_n, rd_n, wr_n;
    logic [15:0] rdata, bdata, idata;

    logic        d2_req0 = 0, d2_req1 = 0, d2_we0 = 0, d2_we1 = 0;
    logic [7:0]  d2_addr0 = 0, d2_addr1 = 0;
    logic [15:0] d2_wdata0 = 0, d2_wdata1 = 0, d2_idata = 0;
    logic        d2_ack0, d2_ack1, d2_busy, d2_cmd, d2_cs_n, d2_rd_n, d2_wr_n;
    logic [15:0] d2_rdata, d2_data;

    always #5 clk = ~clk;

    dm9000a_bus_sequencer u_dut (
        .iCLK(clk), .iRST(rst),
        .iREQ0(req0), .iREQ1(req1), .iWE0(we0), .iWE1(we1),
        .iADDR0(addr0), .iADDR1(addr1), .iWDATA0(wdata0), .iWDATA1(wdata1),
        .oACK0(ack0), .oACK1(ack1), .oRDATA(rdata), .oBUSY(busy),
        .oCMD(cmd), .oCS_N(cs_n), .oRD_N(rd_n), .oWR_N(wr_n),
        .oDATA(bdata), .iDATA(idata)
    );

    dm9000a_bus_sequencer #(.SETUP_CYC(3), .STROBE_CYC(5), .HOLD_CYC(2)) u_dut2 (
        .iCLK(clk), .iRST(rst),
        .iREQ0(d2_req0), .iREQ1(d2_req1), .iWE0(d2_we0), .iWE1(d2_we1),
        .iADDR0(d2_addr0), .iADDR1(d2_addr1), .iWDATA0(d2_wdata0), .iWDATA1(d2_wdata1),
        .oACK0(d2_ack0), .oACK1(d2_ack1), .oRDATA(d2_rdata), .oBUSY(d2_busy),
        .oCMD(d2_cmd), .oCS_N(d2_cs_n), .oRD_N(d2_rd_n), .oWR_N(d2_wr_n),
        .oDATA(d2_data), .iDATA(d2_idata)
    );

    // Bus model and observation counters, all owned by the monitor process
    logic [15:0] mem [256];
    logic [7:0]  cur_idx = 8'h00;
    int idx_cs = 0, dat_cs = 0, idx_wr = 0, dat_wr = 0, rd_idx = 0, rd_dat = 0;
    int ack0_cnt = 0, ack1_cnt = 0, viol = 0;
    logic [15:0] last_idx_data = 0, last_wdata = 0;
    int c2_ics = 0, c2_dcs = 0, c2_iwr = 0, c2_dwr = 0;

    typedef struct { bit port; bit rd; logic [15:0] rdata; } txn_t;
    txn_t expq [$];
    txn_t obsq [$];

    assign idata = mem[cur_idx];

    always @(negedge clk) begin
        txn_t o;
        if (rst) begin
            mem[8'hF2] = 16'hA5C3;
            mem[8'h01] = 16'h5A01;
        end
        if (!cs_n) begin
            if (cmd) dat_cs++; else idx_cs++;
        end
        if (!wr_n && !cs_n) begin
            if (!cmd) begin
                idx_wr++;
                last_idx_data = bdata;
                cur_idx = bdata[7:0];
            end else begin
                dat_wr++;
                last_wdata = bdata;
                mem[cur_idx] = bdata;
            end
        end
        if (!rd_n) begin
            if (cmd) rd_dat++; else rd_idx++;
        end
        if ((!rd_n && !wr_n) || ((!rd_n || !wr_n) && cs_n)) viol++;
        if (ack0) ack0_cnt++;
        if (ack1) ack1_cnt++;
        if (ack0 || ack1) begin
            o.port  = ack1;
            o.rd    = 1'b0;
            o.rdata = rdata;
            obsq.push_back(o);
        end
    end

    always @(negedge clk) begin
        if (!d2_cs_n) begin
            if (d2_cmd) c2_dcs++; else c2_ics++;
        end
        if (!d2_wr_n) begin
            if (d2_cmd) c2_dwr++; else c2_iwr++;
        end
    end

    int n_chk = 0, n_pass = 0;
    logic [15:0] shadow [256];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    task automatic sb_push(input bit port, input bit we, input logic [7:0] addr, input logic [15:0] wd);
        txn_t e;
        e.port  = port;
        e.rd    = !we;
        e.rdata = shadow[addr];
        if (we) shadow[addr] = wd;
        expq.push_back(e);
    endtask

    task automatic sb_drain(input string tag);
        txn_t e, o;
        chk({tag, "_sb_count"}, obsq.size(), expq.size());
        while (obsq.size() > 0 && expq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            chk({tag, "_sb_port"}, o.port, e.port);
            if (e.rd) chk({tag, "_sb_rdata"}, o.rdata, e.rdata);
        end
        obsq.delete();
        expq.delete();
    endtask

    task automatic do_txn(input bit port, input bit we, input logic [7:0] addr,
                          input logic [15:0] wd, input int exp_lat, input bit exp_idx,
                          input string tag);
        int n, b_ics, b_dcs, b_iwr, b_dwr, b_rdi, b_rdd, b_a0, b_a1;
        bit got;
        @(negedge clk);
        b_ics = idx_cs; b_dcs = dat_cs; b_iwr = idx_wr; b_dwr = dat_wr;
        b_rdi = rd_idx; b_rdd = rd_dat; b_a0 = ack0_cnt; b_a1 = ack1_cnt;
        sb_push(port, we, addr, wd);
        if (!port) begin
            req0 = 1; we0 = we; addr0 = addr; wdata0 = wd;
        end else begin
            req1 = 1; we1 = we; addr1 = addr; wdata1 = wd;
        end
        @(posedge clk);
        #1 chk({tag, "_busy"}, busy, 1);
        n = 0;
        got = 0;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (port ? ack1 : ack0) got = 1;
        end
        req0 = 0;
        req1 = 0;
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_idx_cs"}, idx_cs - b_ics, exp_idx ? 4 : 0);
        chk({tag, "_idx_wr"}, idx_wr - b_iwr, exp_idx ? 2 : 0);
        chk({tag, "_dat_cs"}, dat_cs - b_dcs, 4);
        chk({tag, "_dat_strobe"}, we ? (dat_wr - b_dwr) : (rd_dat - b_rdd), 2);
        chk({tag, "_wrong_strobe"}, (we ? (rd_dat - b_rdd) : (dat_wr - b_dwr)) + (rd_idx - b_rdi), 0);
        chk({tag, "_other_ack"}, port ? (ack0_cnt - b_a0) : (ack1_cnt - b_a1), 0);
        if (exp_idx) chk({tag, "_idx_data"}, last_idx_data, {8'h00, addr});
        if (we) chk({tag, "_wdata"}, last_wdata, wd);
        @(negedge clk);
        chk({tag, "_ack_pulse"}, {ack0, ack1}, 2'b00);
        sb_drain(tag);
    endtask

    initial begin
        int n, acks, a0;
        bit got;
        for (int i = 0; i < 256; i++) shadow[i] = 16'h0000;
        shadow[8'hF2] = 16'hA5C3;
        shadow[8'h01] = 16'h5A01;

        repeat (3) @(negedge clk);
        chk("rst_strobes", {cs_n, rd_n, wr_n, cmd}, 4'b1110);
        chk("rst_acks_busy", {ack0, ack1, busy}, 3'b000);
        chk("rst_data", {rdata, bdata}, 32'h0);
        rst = 0;
        @(negedge clk);

        do_txn(0, 1, 8'hFE, 16'h003F, 9, 1, "wr_fe");
        do_txn(1, 0, 8'hF2, 16'h0000, 9, 1, "rd_f2");
        do_txn(1, 0, 8'hF2, 16'h0000, 5, 0, "rd_f2_hit");
        do_txn(1, 0, 8'h01, 16'h0000, 9, 1, "rd_01");
        do_txn(1, 0, 8'hF2, 16'h0000, 9, 1, "rd_f2_again");

        // Simultaneous requests held continuously after reset
        @(negedge clk) rst = 1;
        @(negedge clk) rst = 0;
        sb_push(0, 1, 8'h10, 16'h1111);
        sb_push(1, 0, 8'hF2, 16'h0000);
        sb_push(0, 1, 8'h10, 16'h1111);
        sb_push(1, 0, 8'hF2, 16'h0000);
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 16'h1111;
        req1 = 1; we1 = 0; addr1 = 8'hF2;
        @(posedge clk);
        n = 0;
        acks = 0;
        while (acks < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (ack0 || ack1) begin
                acks++;
                if (acks == 2) chk("rr_second_lat", n, 19);
            end
        end
        req0 = 0;
        req1 = 0;
        chk("rr_total_lat", n, 39);
        @(negedge clk);
        sb_drain("rr");

        // Asynchronous reset during the data strobe of a write
        @(negedge clk);
        a0 = ack0_cnt;
        req0 = 1; we0 = 1; addr0 = 8'h33; wdata0 = 16'h1234;
        got = 0;
        n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (cmd && !wr_n) got = 1;
        end
        chk("abort_reached_strobe", got, 1);
        #1 rst = 1;
        #1;
        chk("abort_strobes", {cs_n, wr_n, rd_n, busy}, 4'b1110);
        chk("abort_data", {rdata, bdata}, 32'h0);
        req0 = 0;
        @(posedge clk);
        @(negedge clk) rst = 0;
        repeat (12) @(negedge clk);
        chk("abort_no_ack", ack0_cnt - a0, 0);
        do_txn(0, 1, 8'h33, 16'h1234, 9, 1, "after_abort");

        // Stretched timing instance
        @(negedge clk);
        d2_req0 = 1; d2_we0 = 1; d2_addr0 = 8'h55; d2_wdata0 = 16'hBEEF;
        @(posedge clk);
        n = 0;
        got = 0;
        while (!got && n < 80) begin
            @(negedge clk);
            n++;
            if (d2_ack0) got = 1;
        end
        d2_req0 = 0;
        chk("p2_lat", n, 21);
        chk("p2_idx_strobe", c2_iwr, 5);
        chk("p2_dat_strobe", c2_dwr, 5);
        chk("p2_idx_cs", c2_ics, 10);
        chk("p2_dat_cs", c2_dcs, 10);
        chk("p2_data", d2_data, 16'hBEEF);

        repeat (3) @(negedge clk);
        chk("strobe_overlap", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
